// File: rtl/iter_div_pkg.sv
// Shared divider types: operation encoding, request bundle and result selector.
package cpuDefine;

    typedef enum logic [1:0] {
        DIVOP_DIV  = 2'd0,
        DIVOP_MOD  = 2'd1,
        DIVOP_DIVU = 2'd2,
        DIVOP_MODU = 2'd3
    } DivOp;

    typedef union packed {
        DivOp       op;
        logic [1:0] raw;
    } DivOpRaw;

    typedef enum logic {
        DIVNEED_QUOT = 1'b0,
        DIVNEED_REM  = 1'b1
    } DivNeed;

    localparam int unsigned DIVREQ_DATA_W = 32;
    localparam int unsigned DIVREQ_TAG_W  = 5;

    typedef struct packed {
        DivOp                     op;
        logic [DIVREQ_DATA_W-1:0] a;
        logic [DIVREQ_DATA_W-1:0] b;
        logic [DIVREQ_TAG_W-1:0]  tag;
    } DivReq;

    function automatic DivNeed div_need(input DivOp op);
        return (op == DIVOP_MOD || op == DIVOP_MODU) ? DIVNEED_REM : DIVNEED_QUOT;
    endfunction

    function automatic logic div_signed(input DivOp op);
        return (op == DIVOP_DIV || op == DIVOP_MOD);
    endfunction

endpackage

// File: rtl/iter_div_step.sv
// One restoring-division step: shift in a dividend bit, subtract divisor, keep if non-negative.
module iter_div_step
    import cpuDefine::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [DATA_W-1:0] rem,
    input  logic              dividend_bit,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W-1:0] rem_next,
    output logic              q_bit
);

    logic [DATA_W:0] partial;
    logic [DATA_W:0] diff;

    always_comb begin
        partial  = {rem, dividend_bit};
        diff     = partial - {1'b0, divisor};
        // Partial remainder < 2*divisor, so the top bit of diff is the borrow.
        q_bit    = ~diff[DATA_W];
        rem_next = q_bit ? diff[DATA_W-1:0] : partial[DATA_W-1:0];
    end

endmodule

// File: rtl/iter_div.sv
// Iterative restoring divider, one quotient bit per clock. Define DIV_FAST_EN to let
// zero-divisor and |a| < |b| requests skip straight to the result.
module iter_div
    import cpuDefine::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned TAG_W  = 5
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_op,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [TAG_W-1:0]  in_tag,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [TAG_W-1:0]  out_tag
);

    localparam int unsigned CntW = $clog2(DATA_W);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} div_state_e;

    div_state_e        state;
    logic [CntW-1:0]   cnt;
    logic [DATA_W-1:0] rem, quo, b_mag, a_raw;
    logic [TAG_W-1:0]  tag_q;
    DivNeed            need_q;
    logic              b_zero_q, neg_q_q, neg_r_q;

    DivOpRaw           op_u;
    logic              in_signed, a_neg, b_neg, in_b_zero;
    logic [DATA_W-1:0] in_a_mag, in_b_mag;
    logic [DATA_W-1:0] rem_next, q_full, final_result;
    logic              q_bit;

    iter_div_step #(.DATA_W(DATA_W)) u_step (
        .rem          (rem),
        .dividend_bit (quo[DATA_W-1]),
        .divisor      (b_mag),
        .rem_next     (rem_next),
        .q_bit        (q_bit)
    );

    always_comb begin
        op_u.raw  = in_op;
        in_signed = div_signed(op_u.op);
        a_neg     = in_signed & in_a[DATA_W-1];
        b_neg     = in_signed & in_b[DATA_W-1];
        in_a_mag  = a_neg ? -in_a : in_a;
        in_b_mag  = b_neg ? -in_b : in_b;
        in_b_zero = (in_b == '0);
        q_full    = {quo[DATA_W-2:0], q_bit};
        if (need_q == DIVNEED_REM) begin
            final_result = b_zero_q ? a_raw : (neg_r_q ? -rem_next : rem_next);
        end else begin
            final_result = b_zero_q ? {DATA_W{1'b1}} : (neg_q_q ? -q_full : q_full);
        end
    end

    assign in_ready = (state == StIdle);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state      <= StIdle;
            cnt        <= '0;
            rem        <= '0;
            quo        <= '0;
            b_mag      <= '0;
            a_raw      <= '0;
            tag_q      <= '0;
            need_q     <= DIVNEED_QUOT;
            b_zero_q   <= 1'b0;
            neg_q_q    <= 1'b0;
            neg_r_q    <= 1'b0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_tag    <= '0;
        end else if (flush) begin
            state     <= StIdle;
            out_valid <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (in_valid) begin
                        need_q   <= div_need(op_u.op);
                        b_zero_q <= in_b_zero;
                        neg_q_q  <= a_neg ^ b_neg;
                        neg_r_q  <= a_neg;
                        a_raw    <= in_a;
                        b_mag    <= in_b_mag;
                        quo      <= in_a_mag;
                        rem      <= '0;
                        cnt      <= CntW'(DATA_W - 1);
                        tag_q    <= in_tag;
`ifdef DIV_FAST_EN
                        // Quotient is trivially zero (or all-ones); remainder is a itself.
                        if (in_b_zero || (in_a_mag < in_b_mag)) begin
                            state      <= StDone;
                            out_valid  <= 1'b1;
                            out_tag    <= in_tag;
                            if (div_need(op_u.op) == DIVNEED_REM) begin
                                out_result <= in_a;
                            end else begin
                                out_result <= in_b_zero ? {DATA_W{1'b1}} : '0;
                            end
                        end else begin
                            state <= StCalc;
                        end
`else
                        state <= StCalc;
`endif
                    end
                end
                StCalc: begin
                    rem <= rem_next;
                    quo <= q_full;
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) begin
                        state      <= StDone;
                        out_valid  <= 1'b1;
                        out_result <= final_result;
                        out_tag    <= tag_q;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state     <= StIdle;
                        out_valid <= 1'b0;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/iter_div.md
ITER_DIV -- requirements
Module: iter_div

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand/result width (even, >=4).
REQ-002 SHALL have parameter TAG_W, default 5, width of the destination-register tag carried with each request.
REQ-003 SHALL have port aclk  in  1  sole clock; all state on its rising edge.
REQ-004 SHALL have port aresetn  in  1  asynchronous active-low reset.
REQ-005 SHALL have port in_valid  in  1  request present.
REQ-006 SHALL have port in_ready  out  1  block can accept; equals (state==IDLE).
REQ-007 SHALL have port in_op  in  2  DivOp: DIVOP_DIV, DIVOP_MOD, DIVOP_DIVU, DIVOP_MODU.
REQ-008 SHALL have port in_a  in  DATA_W  dividend.
REQ-009 SHALL have port in_b  in  DATA_W  divisor.
REQ-010 SHALL have port in_tag  in  TAG_W  opaque tag (rdNo).
REQ-011 SHALL have port flush  in  1  synchronous abort of the in-flight operation.
REQ-012 SHALL have port out_valid  out  1  result present.
REQ-013 SHALL have port out_ready  in  1  consumer accepts result.
REQ-014 SHALL have port out_result  out  DATA_W  quotient or remainder per op.
REQ-015 SHALL have port out_tag  out  TAG_W  tag of the request producing out_result.

Function
REQ-016 SHALL implement FSM IDLE -> CALC -> DONE -> IDLE.
REQ-017 SHALL accept at an edge with in_valid && in_ready && !flush: latch op, tag, operand magnitudes and signs; load counter with DATA_W-1; go CALC.
REQ-018 SHALL in CALC perform one restoring-division step per edge (shift partial remainder left 1, subtract magnitude of b, keep if non-negative, shift quotient bit in), decrementing the counter.
REQ-019 SHALL leave CALC for DONE at the edge where counter==0; out_valid asserts exactly DATA_W edges after the acceptance edge.
REQ-020 SHALL for signed ops use magnitudes: quotient sign = sign(a) XOR sign(b); remainder sign = sign(a); unsigned ops use raw operands.
REQ-021 SHALL on divisor zero return quotient all-ones and remainder = in_a unmodified, for both signed and unsigned ops.
REQ-022 SHALL return quotient 2^(DATA_W-1) and remainder 0 for signed most-negative / -1, with no exception.
REQ-023 SHALL in DONE hold out_valid, out_result and out_tag stable until out_ready; at the edge with out_ready go IDLE.
REQ-024 SHALL not accept a new request in the cycle a result is consumed (in_ready low in DONE).
REQ-025 SHALL on flush go IDLE at the next edge from any state, drop any result, and ignore in_valid in that cycle.

Reset
REQ-026 SHALL on aresetn low immediately force state IDLE, out_valid 0, out_result 0, out_tag 0, counter 0, internal remainder/quotient 0.
REQ-027 SHALL discard any in-flight operation on reset; in_ready is 1 from the first edge after aresetn rises.

Configuration
REQ-028 SHALL support macro DIV_FAST_EN: when defined, a request with divisor zero or |a| < |b| goes IDLE -> DONE directly, out_valid one edge after acceptance, with results per REQ-020/021.
REQ-029 SHALL without DIV_FAST_EN take exactly DATA_W edges for every request, including divisor zero.

Structure
REQ-030 SHALL place DivOp enum (with union for raw bits) and struct DivReq {op, a, b, tag} in package cpuDefine alongside DivNeed.
REQ-031 SHALL use one combinational sub-module iter_div_step computing a single restoring step (next remainder, quotient bit).

Verification (DATA_W=32)
REQ-032 SHALL cover signed: DIV 7/-2 -> 0xFFFFFFFD; MOD 7/-2 -> 1; DIV -7/2 -> 0xFFFFFFFD; MOD -7/2 -> 0xFFFFFFFF.
REQ-033 SHALL cover unsigned: DIVU 0xFFFFFFFF/0x10 -> 0x0FFFFFFF; MODU -> 0xF; tag 0x1A returned on out_tag.
REQ-034 SHALL cover corners: DIV 0x12345678/0 -> 0xFFFFFFFF; MOD -> 0x12345678; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, MOD -> 0.
REQ-035 SHALL cover latency: accept-to-out_valid = 32 edges without macro; with DIV_FAST_EN DIVU 3/5 -> 0 after 1 edge, 100/7 -> 14 after 32.
REQ-036 SHALL cover backpressure/flush: out_ready low 5 cycles -> result and tag stable; flush at iteration 10 -> out_valid never asserts, in_ready high next cycle, following DIVU 9/3 -> 3.
REQ-037 SHALL cover reset mid-CALC: aresetn low at iteration 5 -> out_valid 0 immediately, no stale result after release.
